// File: rtl/pipelined_csel_adder_if.sv
// Operand/result handshake bundle for pipelined_csel_adder.
// The optional subtract-select signal exists only when CSEL_SUB_EN is defined.
interface pipelined_csel_adder_if #(
    parameter int unsigned WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
`ifdef CSEL_SUB_EN
    logic             sub;
`endif
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;

    // Producer of operands and consumer of results
    modport master (
        output in_valid, a, b, cin,
`ifdef CSEL_SUB_EN
        output sub,
`endif
        output out_ready,
        input  in_ready, out_valid, sum, cout
    );

    // The adder itself
    modport slave (
        input  in_valid, a, b, cin,
`ifdef CSEL_SUB_EN
        input  sub,
`endif
        input  out_ready,
        output in_ready, out_valid, sum, cout
    );
endinterface

// File: rtl/pipelined_csel_adder.sv
// Pipelined carry-select adder: {cout, sum} = a + b + cin.
// Each stage resolves WIDTH/STAGES bits using BLK-bit carry-select blocks;
// stage registers carry the resolved low sum, the running carry and the
// still-unresolved upper operand bits. Valid/ready pipeline with bubble
// collapsing, so a full pipeline accepts and delivers in the same cycle.
// Optional feature macro: CSEL_SUB_EN adds a 'sub' input (a + ~b + 1).
module pipelined_csel_adder #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned BLK    = 4,
    parameter int unsigned STAGES = 2
) (
    input logic                   clk,
    input logic                   rst_n,
    pipelined_csel_adder_if.slave bus
);
    localparam int unsigned NBLK = WIDTH / BLK;
    localparam int unsigned BPS  = NBLK / STAGES;
    localparam int unsigned SW   = BPS * BLK;

    if ((STAGES == 0) || (WIDTH % BLK != 0) || (NBLK % STAGES != 0)) begin : g_bad_cfg
        $error("pipelined_csel_adder: illegal WIDTH/BLK/STAGES combination");
    end

    // One stage's worth of carry-select blocks; returns {carry_out, sum}
    function automatic logic [SW:0] csel_seg(
        input logic [SW-1:0] x,
        input logic [SW-1:0] y,
        input logic          c
    );
        logic [SW-1:0] s;
        logic          cy;
        logic [BLK:0]  r0;
        logic [BLK:0]  r1;
        s  = '0;
        cy = c;
        for (int j = 0; j < int'(BPS); j++) begin
            r0 = {1'b0, x[j*BLK +: BLK]} + {1'b0, y[j*BLK +: BLK]};
            r1 = {1'b0, x[j*BLK +: BLK]} + {1'b0, y[j*BLK +: BLK]} + (BLK+1)'(1'b1);
            s[j*BLK +: BLK] = cy ? r1[BLK-1:0] : r0[BLK-1:0];
            cy              = cy ? r1[BLK]     : r0[BLK];
        end
        return {cy, s};
    endfunction

    logic [WIDTH-1:0]  b_eff;
    logic              c_eff;
    logic [STAGES-1:0] vld;
    logic [STAGES-1:0] free;
    logic [STAGES-1:0] src_valid;

    // Operand conditioning at the pipeline entry
`ifdef CSEL_SUB_EN
    assign b_eff = bus.sub ? ~bus.b : bus.b;
    assign c_eff = bus.sub ? 1'b1 : bus.cin;
`else
    assign b_eff = bus.b;
    assign c_eff = bus.cin;
`endif

    // A slot may load when it is empty or its content moves on this cycle
    always_comb begin
        logic nxt;
        free = '0;
        nxt  = bus.out_ready;
        for (int k = int'(STAGES) - 1; k >= 0; k--) begin
            nxt     = !vld[k] || nxt;
            free[k] = nxt;
        end
    end

    // Valid presented to each slot by its predecessor
    always_comb begin
        src_valid    = '0;
        src_valid[0] = bus.in_valid;
        for (int k = 1; k < int'(STAGES); k++) begin
            src_valid[k] = vld[k-1];
        end
    end

    // Slot occupancy; loading an invalid predecessor collapses a bubble
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld <= '0;
        end else begin
            for (int k = 0; k < int'(STAGES); k++) begin
                if (free[k]) begin
                    vld[k] <= src_valid[k];
                end
            end
        end
    end

    for (genvar k = 0; k < int'(STAGES); k++) begin : g_stg
        localparam int unsigned LO = k * SW;
        localparam int unsigned HI = LO + SW;

        logic [SW-1:0] seg_a;
        logic [SW-1:0] seg_b;
        logic          seg_c;
        logic [SW:0]   seg_r;
        logic [HI-1:0] low_d;
        logic [HI-1:0] sum_q;
        logic          cy_q;
        logic          load;

        assign load  = free[k] && src_valid[k];
        assign seg_r = csel_seg(seg_a, seg_b, seg_c);

        if (k == 0) begin : g_head
            assign seg_a = bus.a[SW-1:0];
            assign seg_b = b_eff[SW-1:0];
            assign seg_c = c_eff;
            assign low_d = seg_r[SW-1:0];
        end else begin : g_body
            assign seg_a = g_stg[k-1].g_up.a_q[SW-1:0];
            assign seg_b = g_stg[k-1].g_up.b_q[SW-1:0];
            assign seg_c = g_stg[k-1].cy_q;
            assign low_d = {seg_r[SW-1:0], g_stg[k-1].sum_q};
        end

        // Resolved low sum bits and running carry
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                sum_q <= '0;
                cy_q  <= 1'b0;
            end else if (load) begin
                sum_q <= low_d;
                cy_q  <= seg_r[SW];
            end
        end

        if (HI < WIDTH) begin : g_up
            localparam int unsigned UW = WIDTH - HI;

            logic [UW-1:0] a_d;
            logic [UW-1:0] b_d;
            logic [UW-1:0] a_q;
            logic [UW-1:0] b_q;

            if (k == 0) begin : g_src
                assign a_d = bus.a[WIDTH-1:SW];
                assign b_d = b_eff[WIDTH-1:SW];
            end else begin : g_src
                assign a_d = g_stg[k-1].g_up.a_q[SW +: UW];
                assign b_d = g_stg[k-1].g_up.b_q[SW +: UW];
            end

            // Unresolved upper operand bits travel with the partial result
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    a_q <= '0;
                    b_q <= '0;
                end else if (load) begin
                    a_q <= a_d;
                    b_q <= b_d;
                end
            end
        end
    end

    assign bus.in_ready  = free[0];
    assign bus.out_valid = vld[STAGES-1];
    assign bus.sum       = g_stg[STAGES-1].sum_q;
    assign bus.cout      = g_stg[STAGES-1].cy_q;

endmodule

// File: tb/tb_pipelined_csel_adder.sv
// Self-checking bench for pipelined_csel_adder (WIDTH=32, BLK=4, STAGES=2).
// Optional feature macro: CSEL_SUB_EN exercises the subtract input.
module tb_pipelined_csel_adder;
    localparam int unsigned DEPTH = 2;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        cin;
        logic [31:0] sum;
        logic        cout;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;

    pipelined_csel_adder_if #(.WIDTH(32)) bus ();

    pipelined_csel_adder #(.WIDTH(32), .BLK(4), .STAGES(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    logic [32:0] sbq[$];
    logic [32:0] got[$];
    logic        hold_pending = 1'b0;
    logic [32:0] held;
    logic        sub_mode = 1'b0;
    vec_t        tbl[8];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One cycle: drive at negedge, then check and update the reference queue
    task automatic step(input logic iv, input logic [31:0] ta, input logic [31:0] tb,
                        input logic tc, input logic ordy);
        logic [32:0] e;
        logic [32:0] r;
        @(negedge clk);
        bus.in_valid  = iv;
        bus.a         = ta;
        bus.b         = tb;
        bus.cin       = tc;
        bus.out_ready = ordy;
`ifdef CSEL_SUB_EN
        bus.sub       = sub_mode;
`endif
        #1;
        r = {bus.cout, bus.sum};
        if (hold_pending) check("hold_stable", 64'(r), 64'(held));
        check("in_ready_occupancy", 64'(bus.in_ready),
              64'(!(sbq.size() == DEPTH && !ordy)));
        check("valid_without_pending", 64'(bus.out_valid && sbq.size() == 0), 64'(0));
        if (bus.out_valid && ordy && sbq.size() != 0) begin
            e = sbq.pop_front();
            check("result", 64'(r), 64'(e));
            got.push_back(r);
        end
        hold_pending = bus.out_valid && !ordy;
        held         = r;
        if (iv && bus.in_ready) begin
            if (sub_mode) sbq.push_back(33'(ta) + 33'(~tb) + 33'(1));
            else          sbq.push_back(33'(ta) + 33'(tb) + 33'(tc));
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        #1;
        sbq.delete();
        hold_pending = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          n0;
        int          lat;
        logic [32:0] r;
        logic [31:0] ra;
        logic [31:0] rb;

        tbl[0] = '{32'h00000001, 32'h00000001, 1'b0, 32'h00000002, 1'b0};
        tbl[1] = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b1};
        tbl[2] = '{32'h00000000, 32'h00000000, 1'b1, 32'h00000001, 1'b0};
        tbl[3] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'hFFFFFFFF, 1'b1};
        tbl[4] = '{32'h0000000F, 32'h00000001, 1'b0, 32'h00000010, 1'b0};
        tbl[5] = '{32'h0000FFFF, 32'h00000000, 1'b1, 32'h00010000, 1'b0};
        tbl[6] = '{32'h80000000, 32'h80000000, 1'b0, 32'h00000000, 1'b1};
        tbl[7] = '{32'h12345678, 32'h87654321, 1'b0, 32'h99999999, 1'b0};

        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.cin       = 1'b0;
        bus.out_ready = 1'b0;
`ifdef CSEL_SUB_EN
        bus.sub       = 1'b0;
`endif
        repeat (2) @(negedge clk);
        #1;
        check("reset_out_valid", 64'(bus.out_valid), 64'(0));
        check("reset_sum", 64'(bus.sum), 64'(0));
        check("reset_cout", 64'(bus.cout), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("reset_in_ready", 64'(bus.in_ready), 64'(1));

        // Directed vectors with latency measurement
        for (int i = 0; i < 8; i++) begin
            n0  = got.size();
            lat = 0;
            step(1'b1, tbl[i].a, tbl[i].b, tbl[i].cin, 1'b1);
            while (got.size() == n0 && lat < 10) begin
                step(1'b0, $urandom(), $urandom(), 1'($urandom()), 1'b1);
                lat++;
            end
            if (got.size() == n0) begin
                check($sformatf("vec%0d_timeout", i), 64'(0), 64'(1));
            end else begin
                r = got[$];
                check($sformatf("vec%0d_latency", i), 64'(lat), 64'(2));
                check($sformatf("vec%0d_sum", i), 64'(r[31:0]), 64'(tbl[i].sum));
                check($sformatf("vec%0d_cout", i), 64'(r[32]), 64'(tbl[i].cout));
            end
        end

        // Stall: only two accepted, then release in order with same-cycle refill
        got.delete();
        step(1'b1, 32'hAAAA0004, 32'hABCD0004, 1'b0, 1'b0);
        step(1'b1, 32'hFFFF0006, 32'h12560006, 1'b0, 1'b0);
        step(1'b1, 32'h00000010, 32'h66660010, 1'b0, 1'b0);
        check("stall_in_ready_full", 64'(bus.in_ready), 64'(0));
        step(1'b1, 32'h00000010, 32'h66660010, 1'b0, 1'b0);
        check("stall_in_ready_still_full", 64'(bus.in_ready), 64'(0));
        step(1'b1, 32'h00000010, 32'h66660010, 1'b0, 1'b1);
        check("full_pass_through_in_ready", 64'(bus.in_ready), 64'(1));
        for (int i = 0; i < 6; i++) step(1'b0, 32'hDEADBEEF, 32'hCAFEF00D, 1'b1, 1'b1);
        check("stall_count", 64'(got.size()), 64'(3));
        if (got.size() == 3) begin
            check("stall_res0", 64'(got[0]), 64'(33'h156770008));
            check("stall_res1", 64'(got[1]), 64'(33'h11255000C));
            check("stall_res2", 64'(got[2]), 64'(33'h066660020));
        end

        // Reset with two results in flight
        step(1'b1, 32'h11111111, 32'h22222222, 1'b0, 1'b0);
        step(1'b1, 32'h33333333, 32'h44444444, 1'b1, 1'b0);
        step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        check("pre_reset_out_valid", 64'(bus.out_valid), 64'(1));
        do_reset();
        check("midreset_out_valid", 64'(bus.out_valid), 64'(0));
        check("midreset_sum", 64'(bus.sum), 64'(0));
        check("midreset_cout", 64'(bus.cout), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("post_reset_in_ready", 64'(bus.in_ready), 64'(1));
        n0 = got.size();
        for (int i = 0; i < 5; i++) step(1'b0, $urandom(), $urandom(), 1'b0, 1'b1);
        check("no_stale_after_reset", 64'(got.size()), 64'(n0));

`ifdef CSEL_SUB_EN
        sub_mode = 1'b1;
        got.delete();
        step(1'b1, 32'h00000005, 32'h00000007, 1'b1, 1'b1);
        step(1'b1, 32'h00000007, 32'h00000005, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) step(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
        check("sub_count", 64'(got.size()), 64'(2));
        if (got.size() == 2) begin
            check("sub_5_minus_7", 64'(got[0]), 64'(33'h0FFFFFFFE));
            check("sub_7_minus_5", 64'(got[1]), 64'(33'h100000002));
        end
        sub_mode = 1'b0;
`endif

        // Random stream with random backpressure
        for (int i = 0; i < 2000; i++) begin
            ra = ($urandom_range(0, 7) == 0) ? 32'hFFFFFFFF : $urandom();
            rb = ($urandom_range(0, 7) == 0) ? 32'h00000001 : $urandom();
`ifdef CSEL_SUB_EN
            sub_mode = ($urandom_range(0, 3) == 0);
`endif
            step(($urandom_range(0, 9) < 7), ra, rb, 1'($urandom()),
                 ($urandom_range(0, 9) < 6));
        end
        sub_mode = 1'b0;
        for (int i = 0; i < 20 && sbq.size() != 0; i++) begin
            step(1'b0, $urandom(), $urandom(), 1'b0, 1'b1);
        end
        check("drain_empty", 64'(sbq.size()), 64'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/pipelined_csel_adder.md
PIPELINED_CSEL_ADDER -- requirements
Module: pipelined_csel_adder

Interface
REQ-001 Parameter WIDTH, 32, operand/sum width in bits.
REQ-002 Parameter BLK, 4, carry-select block width in bits; WIDTH % BLK == 0 SHALL hold.
REQ-003 Parameter STAGES, 2, pipeline stages; (WIDTH/BLK) % STAGES == 0 SHALL hold; STAGES >= 1.
REQ-004 clk  input  1  sole clock, rising-edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 in_valid  input  1  operands a, b, cin valid this cycle.
REQ-007 in_ready  output  1  block accepts operands this cycle.
REQ-008 a  input  WIDTH  operand A.
REQ-009 b  input  WIDTH  operand B.
REQ-010 cin  input  1  carry-in.
REQ-011 out_valid  output  1  sum/cout hold a valid result.
REQ-012 out_ready  input  1  downstream accepts result.
REQ-013 sum  output  WIDTH  result bits.
REQ-014 cout  output  1  carry-out of bit WIDTH-1.

Function
REQ-015 Result SHALL equal a + b + cin, with {cout, sum} being WIDTH+1 bits and no truncation of carry.
REQ-016 Each BLK-bit block SHALL compute both carry-in=0 and carry-in=1 sums/carries and select on the incoming block carry; block 0 selects on cin.
REQ-017 Stage k (0..STAGES-1) SHALL resolve blocks k*(WIDTH/BLK/STAGES) through (k+1)*(WIDTH/BLK/STAGES)-1; inter-stage registers carry the resolved low sum bits, the running carry, and the unresolved upper a/b bits.
REQ-018 Transfer in SHALL occur on a rising edge with in_valid && in_ready; transfer out SHALL occur with out_valid && out_ready.
REQ-019 Latency SHALL be exactly STAGES cycles from input transfer to out_valid when no stall occurs; throughput one result per cycle.
REQ-020 Each stage register SHALL advance when it is empty or its successor advances in the same cycle (bubble collapsing); in_ready = stage-0 slot empty or stage 0 advancing.
REQ-021 With out_ready low, the pipeline SHALL hold at most STAGES results; in_ready SHALL drop only when all STAGES slots are full.
REQ-022 sum, cout SHALL remain stable while out_valid && !out_ready.
REQ-023 Results SHALL emerge in acceptance order; none dropped or duplicated.
REQ-024 Simultaneous input and output transfer with a full pipeline SHALL be accepted in the same cycle.
REQ-025 Inputs SHALL be ignored when in_valid is low, regardless of a, b, cin values.

Reset
REQ-026 rst_n low SHALL immediately clear all stage valid bits: out_valid=0, sum=0, cout=0.
REQ-027 in_ready SHALL be 1 in the first cycle after rst_n deasserts.
REQ-028 Reset mid-operation SHALL discard every in-flight result; no stale result appears afterward.

Configuration
REQ-029 Macro CSEL_SUB_EN defined: input port sub (1 bit) added; when sub=1 at transfer, result SHALL be a + ~b + 1 (cin ignored), and cout=1 means no borrow; sub SHALL be captured with the operands.
REQ-030 Macro CSEL_SUB_EN undefined: no sub port; add only per REQ-015.

Verification (WIDTH=32, BLK=4, STAGES=2)
REQ-031 a=0x00000001, b=0x00000001, cin=0, out_ready=1 -> out_valid 2 cycles later, sum=0x00000002, cout=0.
REQ-032 a=0xFFFFFFFF, b=0x00000001, cin=0 -> sum=0x00000000, cout=1 (full carry ripple across all blocks and stages).
REQ-033 out_ready=0, offer 0xAAAA0004+0xABCD0004, 0xFFFF0006+0x12560006, 0x00000010+0x66660010 back-to-back -> only the first two accepted, in_ready=0; raise out_ready -> results 0x56770008/cout1, 0x1255000C/cout1, then the third 0x66660020/cout0, in order.
REQ-034 Two transactions in flight, pulse rst_n low one cycle -> out_valid=0 immediately, no result emerges afterward, in_ready=1 after release.
REQ-035 CSEL_SUB_EN defined, sub=1, a=0x00000005, b=0x00000007 -> sum=0xFFFFFFFE, cout=0; a=7, b=5 -> sum=0x00000002, cout=1.
REQ-036 Random back-to-back stream, out_ready toggled randomly -> every result matches a+b+cin, order preserved, no loss.
